audio_attenuation_matrix: RTL and testbench

//   Parametrised N-channel audio attenuation/mixing matrix: out[o] = sat(sum_i gain[o][i]*in[i] >> FACTOR_W).

---
 rtl/audio_attenuation_matrix.sv | 230 +++++++++++++++++++++++
 tb/tb_audio_attenuation_matrix.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_attenuation_matrix.sv
// N-channel audio attenuation/mixing matrix with serially loaded gains and a shared time-multiplexed MAC.
// Optional build macro VOLUME_RAMP_EN: per-frame slewing of active gains toward their loaded targets.
module audio_attenuation_matrix #(
    parameter int CHANNELS  = 2,
    parameter int SAMPLE_W  = 16,
    parameter int FACTOR_W  = 8,
    parameter int RAMP_STEP = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         datadac,
    input  logic                         clkdac,
    input  logic [CHANNELS-1:0]          csdac_n,
    input  logic                         kill,
    input  logic                         in_valid,
    input  logic [CHANNELS*SAMPLE_W-1:0] audio_in,
    output logic [CHANNELS*SAMPLE_W-1:0] audio_out,
    output logic                         out_valid,
    output logic                         busy,
    output logic                         overrun
);

    localparam int IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int SR_W   = IDX_W + FACTOR_W;
    localparam int PROD_W = SAMPLE_W + FACTOR_W + 1;
    localparam int ACC_W  = PROD_W + IDX_W;

    typedef logic [FACTOR_W-1:0] gain_t;
    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef enum logic {ST_IDLE, ST_MAC} state_t;

    localparam gain_t UNITY = '1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);
    localparam logic signed [ACC_W-1:0] POS_LIM = {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] NEG_LIM = -POS_LIM;

    // ------------------------------------------------------------------
    // Control bus synchronisers and edge detection
    // ------------------------------------------------------------------
    logic                dat_meta_q, dat_sync_q;
    logic                clk_meta_q, clk_sync_q, clk_prev_q;
    logic [CHANNELS-1:0] cs_meta_q, cs_sync_q, cs_prev_q;
    logic                clkdac_rise;
    logic [CHANNELS-1:0] cs_fall;

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dat_meta_q <= 1'b0;
            dat_sync_q <= 1'b0;
            clk_meta_q <= 1'b0;
            clk_sync_q <= 1'b0;
            clk_prev_q <= 1'b0;
            cs_meta_q  <= '1;
            cs_sync_q  <= '1;
            cs_prev_q  <= '1;
        end else begin
            dat_meta_q <= datadac;
            dat_sync_q <= dat_meta_q;
            clk_meta_q <= clkdac;
            clk_sync_q <= clk_meta_q;
            clk_prev_q <= clk_sync_q;
            cs_meta_q  <= csdac_n;
            cs_sync_q  <= cs_meta_q;
            cs_prev_q  <= cs_sync_q;
        end
    end

    assign clkdac_rise = clk_sync_q & ~clk_prev_q;
    assign cs_fall     = cs_prev_q & ~cs_sync_q;

    // ------------------------------------------------------------------
    // Gain shift register and target gain matrix
    // ------------------------------------------------------------------
    logic [SR_W-1:0]  sr_q;
    logic [IDX_W-1:0] wr_idx;
    gain_t            wr_gain;
    gain_t            target_q [CHANNELS][CHANNELS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_q <= '0;
        end else if (clkdac_rise) begin
            sr_q <= {sr_q[SR_W-2:0], dat_sync_q};
        end
    end

    assign wr_idx  = sr_q[SR_W-1:FACTOR_W];
    assign wr_gain = sr_q[FACTOR_W-1:0];

    // NOTE: the gain matrix is a small flop array, not RAM, and must come out of reset as identity.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int o = 0; o < CHANNELS; o++)
                for (int i = 0; i < CHANNELS; i++)
                    target_q[o][i] <= (o == i) ? UNITY : '0;
        end else begin
            // A shift on the same cycle as a strobe lands after this write, so the row gets the old word.
            for (int o = 0; o < CHANNELS; o++)
                if (cs_fall[o] && int'(wr_idx) < CHANNELS)
                    target_q[o][wr_idx] <= wr_gain;
        end
    end

    // ------------------------------------------------------------------
    // Frame control and MAC datapath
    // ------------------------------------------------------------------
    state_t                    state_q;
    logic [IDX_W-1:0]          o_q, i_q;
    logic signed [ACC_W-1:0]   acc_q;
    sample_t                   samp_q [CHANNELS];
    sample_t                   out_q  [CHANNELS];
    logic                      out_valid_q, overrun_q;
    logic                      accept;

    gain_t                     mac_gain;
    logic signed [PROD_W-1:0]  gain_ext, samp_ext, mac_prod;
    logic signed [ACC_W-1:0]   mac_sum, mac_shift;
    sample_t                   mac_result;

    assign accept = in_valid && (state_q == ST_IDLE);

`ifdef VOLUME_RAMP_EN
    localparam logic [FACTOR_W:0] STEP_X = (FACTOR_W+1)'(RAMP_STEP);

    gain_t active_q [CHANNELS][CHANNELS];

    function automatic gain_t ramp_toward(input gain_t cur, input gain_t tgt);
        logic [FACTOR_W:0] cur_x, tgt_x;
        cur_x       = {1'b0, cur};
        tgt_x       = {1'b0, tgt};
        ramp_toward = tgt;
        if (cur_x + STEP_X < tgt_x)
            ramp_toward = cur + STEP_X[FACTOR_W-1:0];
        else if (tgt_x + STEP_X < cur_x)
            ramp_toward = cur - STEP_X[FACTOR_W-1:0];
    endfunction

    // Active gains move once per accepted frame, before that frame's first product.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int o = 0; o < CHANNELS; o++)
                for (int i = 0; i < CHANNELS; i++)
                    active_q[o][i] <= (o == i) ? UNITY : '0;
        end else if (accept) begin
            for (int o = 0; o < CHANNELS; o++)
                for (int i = 0; i < CHANNELS; i++)
                    active_q[o][i] <= ramp_toward(active_q[o][i], target_q[o][i]);
        end
    end

    assign mac_gain = active_q[o_q][i_q];
`else
    logic ramp_step_unused;
    assign ramp_step_unused = (RAMP_STEP != 0);
    assign mac_gain         = target_q[o_q][i_q];
`endif

    // NOTE: every always_comb output gets a default first, which rules out latches on any path.
    always_comb begin
        gain_ext   = PROD_W'($signed({1'b0, mac_gain}));
        samp_ext   = PROD_W'(samp_q[i_q]);
        mac_prod   = gain_ext * samp_ext;
        mac_sum    = acc_q + ACC_W'(mac_prod);
        mac_shift  = mac_sum >>> FACTOR_W;
        mac_result = mac_shift[SAMPLE_W-1:0];
        if (mac_shift > POS_LIM)
            mac_result = POS_LIM[SAMPLE_W-1:0];
        else if (mac_shift < NEG_LIM)
            mac_result = NEG_LIM[SAMPLE_W-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            o_q         <= '0;
            i_q         <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                samp_q[c] <= '0;
                out_q[c]  <= '0;
            end
        end else begin
            out_valid_q <= 1'b0;
            overrun_q   <= in_valid && (state_q == ST_MAC);
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        for (int c = 0; c < CHANNELS; c++)
                            samp_q[c] <= audio_in[c*SAMPLE_W +: SAMPLE_W];
                        acc_q   <= '0;
                        o_q     <= '0;
                        i_q     <= '0;
                        state_q <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    if (i_q == LAST_IDX) begin
                        out_q[o_q] <= kill ? '0 : mac_result;
                        acc_q      <= '0;
                        i_q        <= '0;
                        if (o_q == LAST_IDX) begin
                            state_q     <= ST_IDLE;
                            out_valid_q <= 1'b1;
                        end else begin
                            o_q <= o_q + IDX_W'(1);
                        end
                    end else begin
                        acc_q <= mac_sum;
                        i_q   <= i_q + IDX_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        audio_out = '0;
        for (int c = 0; c < CHANNELS; c++)
            audio_out[c*SAMPLE_W +: SAMPLE_W] = out_q[c];
    end

    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q == ST_MAC);

endmodule

// File: tb/tb_audio_attenuation_matrix.sv
// Self-checking bench for audio_attenuation_matrix (N=2, 16-bit samples, 8-bit gains).
// Expected outputs come from an arithmetic gain-matrix model kept in the bench.
module tb_audio_attenuation_matrix;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        datadac;
    logic        clkdac;
    logic [1:0]  csdac_n;
    logic        kill;
    logic        in_valid;
    logic [31:0] audio_in;
    logic [31:0] audio_out;
    logic        out_valid;
    logic        busy;
    logic        overrun;

    int checks   = 0;
    int failures = 0;

    // Model state: loaded targets and (ramp build) the slewed active copies.
    int tgt [2][2];
    int act [2][2];

    audio_attenuation_matrix #(
        .CHANNELS (2),
        .SAMPLE_W (16),
        .FACTOR_W (8),
        .RAMP_STEP(16)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .datadac  (datadac),
        .clkdac   (clkdac),
        .csdac_n  (csdac_n),
        .kill     (kill),
        .in_valid (in_valid),
        .audio_in (audio_in),
        .audio_out(audio_out),
        .out_valid(out_valid),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int o = 0; o < 2; o++)
            for (int i = 0; i < 2; i++) begin
                tgt[o][i] = (o == i) ? 255 : 0;
                act[o][i] = tgt[o][i];
            end
    endtask

    task automatic model_accept();
        for (int o = 0; o < 2; o++)
            for (int i = 0; i < 2; i++) begin
                if (act[o][i] < tgt[o][i])
                    act[o][i] = (act[o][i] + 16 > tgt[o][i]) ? tgt[o][i] : act[o][i] + 16;
                else
                    act[o][i] = (act[o][i] - 16 < tgt[o][i]) ? tgt[o][i] : act[o][i] - 16;
            end
    endtask

    function automatic int used_gain(input int o, input int i);
`ifdef VOLUME_RAMP_EN
        return act[o][i];
`else
        return tgt[o][i];
`endif
    endfunction

    // out = clip(floor(sum(gain*in) / 256)) to +-32767
    function automatic logic [15:0] expect_out(input int o, input logic [15:0] x0, input logic [15:0] x1);
        longint sum, q;
        logic [15:0] r;
        sum = longint'(used_gain(o, 0)) * longint'($signed(x0))
            + longint'(used_gain(o, 1)) * longint'($signed(x1));
        q = sum / 256;
        if (sum < 0 && q * 256 != sum) q = q - 1;
        if (q > 32767) q = 32767;
        if (q < -32767) q = -32767;
        r = 16'(q);
        return r;
    endfunction

    task automatic write_gain(input int o, input int idx, input int g);
        logic [8:0] word;
        word = {1'(idx), 8'(g)};
        for (int b = 8; b >= 0; b--) begin
            datadac = word[b];
            repeat (3) tick();
            clkdac = 1'b1;
            repeat (3) tick();
            clkdac = 1'b0;
            repeat (3) tick();
        end
        csdac_n[o] = 1'b0;
        repeat (4) tick();
        csdac_n[o] = 1'b1;
        repeat (4) tick();
        tgt[o][idx] = g;
    endtask

    // Launch one frame, check accept, latency and both outputs; returns in the out_valid cycle.
    task automatic run_frame(input logic [15:0] x0, input logic [15:0] x1, input string tag,
                             output logic [15:0] got0, output logic [15:0] got1);
        logic [15:0] e0, e1;
        int lat;
        audio_in = {x1, x0};
        in_valid = 1'b1;
        model_accept();
        e0 = kill ? 16'h0 : expect_out(0, x0, x1);
        e1 = kill ? 16'h0 : expect_out(1, x0, x1);
        tick();
        in_valid = 1'b0;
        audio_in = $urandom;
        check({tag, " busy_after_accept"}, 32'(busy), 32'd1);
        check({tag, " no_overrun_on_accept"}, 32'(overrun), 32'd0);
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, lat, 5);
        check({tag, " busy_at_out_valid"}, 32'(busy), 32'd0);
        got0 = audio_out[15:0];
        got1 = audio_out[31:16];
        check({tag, " out0"}, 32'(got0), 32'(e0));
        check({tag, " out1"}, 32'(got1), 32'(e1));
    endtask

    function automatic logic [15:0] rand_sample();
        case ($urandom_range(0, 3))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        logic [15:0] r0, r1;
        logic [15:0] cap0, cap1;
        int nvalid;

        // ---- reset state ----
        reset_n  = 1'b0;
        datadac  = 1'b0;
        clkdac   = 1'b0;
        csdac_n  = 2'b11;
        kill     = 1'b0;
        in_valid = 1'b0;
        audio_in = '0;
        model_reset();
        repeat (3) tick();
        check("reset audio_out", audio_out, 32'h0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset overrun", 32'(overrun), 32'd0);
        reset_n = 1'b1;
        repeat (2) tick();

        // ---- identity gains ----
        run_frame(16'h4000, 16'hC000, "identity", r0, r1);
        check("identity const out0", 32'(r0), 32'h3FC0);
        check("identity const out1", 32'(r1), 32'hC040);
        tick();
        check("out_valid one cycle", 32'(out_valid), 32'd0);

        // ---- serial gain load: gain[0][1]=0x80 ----
        write_gain(0, 1, 8'h80);
        run_frame(16'h4000, 16'h4000, "mix80", r0, r1);
`ifndef VOLUME_RAMP_EN
        check("mix80 const out0", 32'(r0), 32'h5FC0);
        check("mix80 const out1", 32'(r1), 32'h3FC0);
`endif

        // ---- saturation, gain[0][1]=0xFF ----
        write_gain(0, 1, 8'hFF);
        run_frame(16'h7FFF, 16'h7FFF, "clip_pos", r0, r1);
`ifndef VOLUME_RAMP_EN
        check("clip_pos const out0", 32'(r0), 32'h7FFF);
`endif
        run_frame(16'h8000, 16'h8000, "clip_neg", r0, r1);
`ifndef VOLUME_RAMP_EN
        check("clip_neg const out0", 32'(r0), 32'h8001);
`endif

        // ---- overrun: second in_valid two cycles after accept ----
        tick();
        audio_in = {16'h1234, 16'h2345};
        in_valid = 1'b1;
        model_accept();
        r0 = expect_out(0, 16'h2345, 16'h1234);
        r1 = expect_out(1, 16'h2345, 16'h1234);
        tick();
        in_valid = 1'b0;
        tick();
        audio_in = {16'h7000, 16'h9000};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("overrun pulse", 32'(overrun), 32'd1);
        tick();
        check("overrun one cycle", 32'(overrun), 32'd0);
        nvalid = 0;
        cap0 = '0;
        cap1 = '0;
        for (int k = 0; k < 12; k++) begin
            if (out_valid) begin
                nvalid++;
                cap0 = audio_out[15:0];
                cap1 = audio_out[31:16];
            end
            tick();
        end
        check("overrun single out_valid", nvalid, 1);
        check("overrun snapshot out0", 32'(cap0), 32'(r0));
        check("overrun snapshot out1", 32'(cap1), 32'(r1));

        // ---- kill ----
        kill = 1'b1;
        run_frame(16'h5555, 16'h2222, "kill", r0, r1);
        kill = 1'b0;
        tick();

        // ---- randomized frames, back-to-back with occasional gain reloads ----
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                tick();
                write_gain(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
            end
            run_frame(rand_sample(), rand_sample(), $sformatf("rand%0d", n), r0, r1);
        end
        tick();

`ifdef VOLUME_RAMP_EN
        // ---- ramp: target[0][0]=0 slews down by 16 per accepted frame ----
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        model_reset();
        tick();
        write_gain(0, 0, 0);
        for (int f = 1; f <= 16; f++) begin
            run_frame(16'h4000, 16'h0000, $sformatf("ramp%0d", f), r0, r1);
            check($sformatf("ramp%0d const out0", f), 32'(r0),
                  32'(16'(((f == 16) ? 0 : 255 - 16 * f) * 64)));
        end
        tick();
`endif

        // ---- async reset mid-frame ----
        run_frame(16'h4000, 16'h4000, "pre_reset", r0, r1);
        tick();
        audio_in = {16'h3000, 16'h3000};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        reset_n = 1'b0;
        #1;
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset audio_out", audio_out, 32'h0);
        check("midreset out_valid", 32'(out_valid), 32'd0);
        tick();
        reset_n = 1'b1;
        model_reset();
        nvalid = 0;
        for (int k = 0; k < 10; k++) begin
            if (out_valid) nvalid++;
            tick();
        end
        check("midreset no out_valid", nvalid, 0);
        run_frame(16'h4000, 16'hC000, "post_reset", r0, r1);
        check("post_reset const out0", 32'(r0), 32'h3FC0);
        check("post_reset const out1", 32'(r1), 32'hC040);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
